scene_seq: RTL and testbench

Scene sequencer for the game's VGA output path. Tracks play / death / game-over / restart phases, freezes and resets the game core, and selects per pixel between the live game layer and the game-over banner layer. It sits between the game renderer, the game-over banner renderer and the VGA pixel output register.

---
 rtl/scene_seq_pkg.sv | 13 +
 rtl/scene_seq_frame_counter.sv | 29 ++
 rtl/scene_seq.sv | 121 ++++++++++++
 tb/tb_scene_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/scene_seq_pkg.sv
// Shared types and widths for the scene sequencer: state encodings, pixel width
// and frame counter width.
package scene_pkg;
  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    DYING   = 2'd1,
    OVER    = 2'd2,
    RESTART = 2'd3
  } state_t;

  localparam int RGB_W = 12;
  localparam int CNT_W = 8;
endpackage

// File: rtl/scene_seq_frame_counter.sv
// Tick-enabled saturating frame counter with synchronous clear and a
// terminal-count flag that fires on the tick that would reach 'term'.
module frame_counter
  import scene_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  logic [CNT_W-1:0] inc;

  // Saturate at all-ones so a long wait never wraps back to zero.
  assign inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  assign tc  = tick && (inc == term);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= inc;
    end
  end
endmodule

// File: rtl/scene_seq.sv
// Scene sequencer: PLAY/DYING/OVER/RESTART phases, game core freeze/reset and
// registered game/banner pixel select. Optional banner blink: SCENE_BLINK_EN.
module scene_seq
  import scene_pkg::*;
#(
  parameter int               DEATH_FRAMES = 50,
  parameter int               BLINK_FRAMES = 30,
  parameter logic [RGB_W-1:0] BG_RGB       = 12'h000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             frame_tick,
  input  logic             death,
  input  logic             restart_key,
  input  logic [RGB_W-1:0] game_rgb,
  input  logic             banner_hit,
  input  logic [RGB_W-1:0] banner_rgb,
  output logic             game_freeze,
  output logic             game_reset,
  output logic [1:0]       scene,
  output logic [RGB_W-1:0] rgb_out
);
  state_t           state, state_nxt;
  logic             key_prev;
  logic             key_edge;
  logic             blink_on;
  logic             blink_tgl;
  logic             cnt_clr;
  logic             cnt_tick;
  logic             cnt_tc;
  logic [CNT_W-1:0] cnt_term;
  logic [CNT_W-1:0] frame_cnt;

  assign key_edge = restart_key & ~key_prev;
  assign cnt_term = (state == OVER) ? BLINK_FRAMES[CNT_W-1:0] : DEATH_FRAMES[CNT_W-1:0];

  frame_counter u_frame_counter (
    .clk  (clk),
    .rstn (rstn),
    .clr  (cnt_clr),
    .tick (cnt_tick),
    .term (cnt_term),
    .cnt  (frame_cnt),
    .tc   (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= PLAY;
      key_prev <= 1'b0;
      blink_on <= 1'b1;
    end else begin
      state    <= state_nxt;
      key_prev <= restart_key;
      if (state == DYING && state_nxt == OVER) begin
        blink_on <= 1'b1;
      end else if (blink_tgl) begin
        blink_on <= ~blink_on;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_tick  = 1'b0;
    blink_tgl = 1'b0;
    case (state)
      PLAY: begin
        cnt_clr = 1'b1;
        if (death) state_nxt = DYING;
      end
      DYING: begin
        cnt_tick = frame_tick;
        if (cnt_tc) begin
          state_nxt = OVER;
          cnt_clr   = 1'b1;
        end
      end
      OVER: begin
`ifdef SCENE_BLINK_EN
        cnt_tick = frame_tick;
        if (cnt_tc) begin
          cnt_clr   = 1'b1;
          blink_tgl = 1'b1;
        end
`else
        cnt_tick = 1'b0;
`endif
        // Edge is qualified against the previous level, so a key held
        // through DYING cannot fire here.
        if (key_edge) begin
          state_nxt = RESTART;
          cnt_clr   = 1'b1;
        end
      end
      RESTART: begin
        cnt_clr   = 1'b1;
        state_nxt = PLAY;
      end
      default: state_nxt = PLAY;
    endcase
  end

  assign game_freeze = (state != PLAY);
  assign game_reset  = (state == RESTART);
  assign scene       = state;

  // Pixel stage: selected from the state held in the same cycle as the pixel inputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rgb_out <= '0;
    end else begin
      case (state)
        PLAY, DYING: rgb_out <= game_rgb;
        OVER:        rgb_out <= (banner_hit && blink_on) ? banner_rgb : BG_RGB;
        default:     rgb_out <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_scene_seq.sv
// Directed vector bench for scene_seq (DEATH_FRAMES=3, BLINK_FRAMES=2, BG=0A5).
module tb_scene_seq;
  localparam logic [11:0] BG = 12'h0A5;

  logic        clk = 1'b0;
  logic        rstn;
  logic        frame_tick;
  logic        death;
  logic        restart_key;
  logic [11:0] game_rgb;
  logic        banner_hit;
  logic [11:0] banner_rgb;
  logic        game_freeze;
  logic        game_reset;
  logic [1:0]  scene;
  logic [11:0] rgb_out;

  int total = 0;
  int bad   = 0;

  scene_seq #(
    .DEATH_FRAMES (3),
    .BLINK_FRAMES (2),
    .BG_RGB       (BG)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .frame_tick  (frame_tick),
    .death       (death),
    .restart_key (restart_key),
    .game_rgb    (game_rgb),
    .banner_hit  (banner_hit),
    .banner_rgb  (banner_rgb),
    .game_freeze (game_freeze),
    .game_reset  (game_reset),
    .scene       (scene),
    .rgb_out     (rgb_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        death;
    logic        key;
    logic        tick;
    logic        hit;
    logic [11:0] banner;
    logic [11:0] game;
    logic [1:0]  sc;
    logic        frz;
    logic        rst;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int idx, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string name, input int idx, input logic [1:0] sc,
                         input logic frz, input logic rst);
    chk({name, "_scene"}, idx, {10'd0, scene}, {10'd0, sc});
    chk({name, "_freeze"}, idx, {11'd0, game_freeze}, {11'd0, frz});
    chk({name, "_reset"}, idx, {11'd0, game_reset}, {11'd0, rst});
  endtask

  logic [11:0] exp_rgb;
  logic        bon;
  int          bcnt;

  initial begin
    //           death key tick hit banner  game    sc   frz  rst  rgb
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h123, 2'd0, 1'b0, 1'b0, 12'h123};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 12'h456, 2'd1, 1'b1, 1'b0, 12'h456};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 12'h789, 2'd1, 1'b1, 1'b0, 12'h789};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h111, 2'd1, 1'b1, 1'b0, 12'h111};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 12'h222, 2'd1, 1'b1, 1'b0, 12'h222};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 12'h333, 2'd2, 1'b1, 1'b0, 12'h333};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 12'hF00, 12'h999, 2'd2, 1'b1, 1'b0, 12'hF00};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'hF00, 12'h999, 2'd2, 1'b1, 1'b0, BG};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 12'hF00, 12'h999, 2'd2, 1'b1, 1'b0, 12'hF00};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h0F0, 12'h999, 2'd2, 1'b1, 1'b0, 12'h0F0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h0F0, 12'h999, 2'd3, 1'b1, 1'b1, BG};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h00F, 12'h444, 2'd0, 1'b0, 1'b0, 12'h000};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h00F, 12'h555, 2'd1, 1'b1, 1'b0, 12'h555};

    rstn = 1'b0; frame_tick = 1'b0; death = 1'b0; restart_key = 1'b0;
    game_rgb = 12'h7E7; banner_hit = 1'b0; banner_rgb = 12'h000;
    step();
    step();
    chk_ctl("reset", 0, 2'd0, 1'b0, 1'b0);
    chk("reset_rgb", 0, rgb_out, 12'h000);
    rstn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      death = vecs[i].death; restart_key = vecs[i].key; frame_tick = vecs[i].tick;
      banner_hit = vecs[i].hit; banner_rgb = vecs[i].banner; game_rgb = vecs[i].game;
      step();
      chk_ctl("vec", i, vecs[i].sc, vecs[i].frz, vecs[i].rst);
      chk("vec_rgb", i, rgb_out, vecs[i].rgb);
    end

    // DYING with ticks every 10 cycles; OVER one cycle after the third tick.
    death = 1'b0; restart_key = 1'b0; game_rgb = 12'h321;
    for (int t = 1; t <= 3; t++) begin
      frame_tick = 1'b0;
      for (int c = 0; c < 9; c++) begin
        step();
        chk_ctl("dying_wait", t * 10 + c, 2'd1, 1'b1, 1'b0);
      end
      frame_tick = 1'b1;
      step();
      chk_ctl("dying_tick", t, (t == 3) ? 2'd2 : 2'd1, 1'b1, 1'b0);
    end
    frame_tick = 1'b0;

    // OVER with an opaque banner: blink model or static banner.
    banner_hit = 1'b1; banner_rgb = 12'hF00;
    bon = 1'b1; bcnt = 0;
    for (int c = 0; c < 24; c++) begin
      frame_tick = (c % 4 == 3);
      exp_rgb = bon ? 12'hF00 : BG;
      step();
      chk("over_rgb", c, rgb_out, exp_rgb);
      chk_ctl("over_hold", c, 2'd2, 1'b1, 1'b0);
`ifdef SCENE_BLINK_EN
      if (frame_tick) begin
        bcnt++;
        if (bcnt == 2) begin
          bon = ~bon;
          bcnt = 0;
        end
      end
`endif
    end
    frame_tick = 1'b0;

    // Single-cycle reset mid-OVER.
    rstn = 1'b0;
    step();
    chk_ctl("midreset", 0, 2'd0, 1'b0, 1'b0);
    chk("midreset_rgb", 0, rgb_out, 12'h000);
    rstn = 1'b1; game_rgb = 12'hABC;
    step();
    chk_ctl("after_reset", 0, 2'd0, 1'b0, 1'b0);
    chk("after_reset_rgb", 0, rgb_out, 12'hABC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
